// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, hex glyph table and the
// reader's FSM state type.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Index i holds the glyph displayed for hex value i.
   localparam logic [6:0] SEG7_GLYPH [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [6:0] SEG7_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } seg7_state_e;

endpackage

// File: rtl/seven_segment_pattern_match.sv
// Combinational reverse lookup of a segment pattern into its hex value.
module seven_segment_pattern_match
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       hit,
   output logic       blank,
   output logic [3:0] value
);

   always_comb begin
      hit   = 1'b0;
      value = 4'h0;
      blank = (pattern == SEG7_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (pattern == SEG7_GLYPH[i]) begin
            hit   = 1'b1;
            value = i[3:0];
         end
      end
   end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a multiplexed 7-segment bus, debounces each digit slot and
// reconstructs the displayed hex digits.
module seven_segment_reader
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [6:0]                seg_in,
   input  logic [NUM_DIGITS-1:0]     dig_sel,
   input  logic                      err_clr,
   output logic [4*NUM_DIGITS-1:0]   digits_out,
   output logic [NUM_DIGITS-1:0]     valid_mask,
   output logic                      pattern_err,
   output logic                      frame_done
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int SW = NUM_DIGITS + 7;

   logic [6:0]              seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
   logic [NUM_DIGITS-1:0]   dig_meta_q, dig_meta_d, dig_sync_q, dig_sync_d;
   logic [SW-1:0]           prev_q, prev_d;
   seg7_state_e             state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic                    err_q, err_d;
   logic [NUM_DIGITS-1:0]   captured_q, captured_d, captured_acc;
   logic                    frame_done_q, frame_done_d;

   logic [SW-1:0] sample;
   logic          one_hot, changed, capture;
   logic          hit, blank;
   logic [3:0]    value;

   seven_segment_pattern_match u_match (
      .pattern (seg_sync_q),
      .hit     (hit),
      .blank   (blank),
      .value   (value)
   );

   always_comb begin
      seg_meta_d = seg_in;
      seg_sync_d = seg_meta_q;
      dig_meta_d = dig_sel;
      dig_sync_d = dig_meta_q;

      sample  = {dig_sync_q, seg_sync_q};
      prev_d  = sample;
      one_hot = (dig_sync_q != '0) &&
                ((dig_sync_q & (dig_sync_q - NUM_DIGITS'(1))) == '0);
      changed = (sample != prev_q);

      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;

      if (!one_hot) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (changed || state_q == IDLE) begin
         state_d = SETTLE;
         cnt_d   = CW'(1);
      end else if (state_q == SETTLE) begin
         // cnt_q counts samples already seen; this one completes the window.
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_d = HOLD;
         end
      end

      digits_d = digits_q;
      valid_d  = valid_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (capture && dig_sync_q[k]) begin
            if (hit) begin
               digits_d[4*k +: 4] = value;
            end else if (blank) begin
               digits_d[4*k +: 4] = 4'h0;
            end
            valid_d[k] = hit;
         end
      end

      // A set in the same cycle as a clear must win.
      err_d = err_q & ~err_clr;
      if (capture && !hit && !blank) begin
         err_d = 1'b1;
      end

      captured_acc = captured_q | (capture ? dig_sync_q : '0);
      frame_done_d = 1'b0;
      captured_d   = captured_acc;
      if (&captured_acc) begin
         frame_done_d = 1'b1;
         captured_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_meta_q   <= '0;
         seg_sync_q   <= '0;
         dig_meta_q   <= '0;
         dig_sync_q   <= '0;
         prev_q       <= '0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         digits_q     <= '0;
         valid_q      <= '0;
         err_q        <= 1'b0;
         captured_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         seg_meta_q   <= seg_meta_d;
         seg_sync_q   <= seg_sync_d;
         dig_meta_q   <= dig_meta_d;
         dig_sync_q   <= dig_sync_d;
         prev_q       <= prev_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         digits_q     <= digits_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         captured_q   <= captured_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digits_out  = digits_q;
   assign valid_mask  = valid_q;
   assign pattern_err = err_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed-vector bench for seven_segment_reader (NUM_DIGITS=4, STABLE_CYCLES=16).
module tb_seven_segment_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic        err_clr;
   logic [15:0] digits_out;
   logic [3:0]  valid_mask;
   logic        pattern_err;
   logic        frame_done;

   int n_checks = 0;
   int n_pass   = 0;
   int fd_pulses;
   int pulse_slot;

   seven_segment_reader #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .dig_sel     (dig_sel),
      .err_clr     (err_clr),
      .digits_out  (digits_out),
      .valid_mask  (valid_mask),
      .pattern_err (pattern_err),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("check %-16s obs=%0h exp=%0h ok", tag, obs, exp);
      end else begin
         $display("FAIL %-16s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 ns after each edge and counting pulses.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (frame_done === 1'b1) fd_pulses++;
      end
   endtask

   task automatic scan(output int pulses, output int slot);
      logic [6:0] glyph [0:3];
      glyph[0] = 7'h06;
      glyph[1] = 7'h5B;
      glyph[2] = 7'h4F;
      glyph[3] = 7'h66;
      pulses = 0;
      slot   = -1;
      for (int d = 0; d < 4; d++) begin
         dig_sel = 4'b0001 << d;
         seg_in  = glyph[d];
         for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) begin
               pulses++;
               slot = d;
            end
         end
      end
   endtask

   initial begin
      int p, s;
      rst     = 1'b1;
      seg_in  = 7'h00;
      dig_sel = 4'b0000;
      err_clr = 1'b0;
      fd_pulses = 0;
      step(3);
      rst = 1'b0;
      check("rst_digits", 32'(digits_out), 32'h0);
      check("rst_valid",  32'(valid_mask), 32'h0);
      check("rst_err",    32'(pattern_err), 32'h0);
      check("rst_fd",     32'(frame_done), 32'h0);

      // Single capture: visible on the 18th edge, not the 17th.
      dig_sel = 4'b0001;
      seg_in  = 7'h5B;
      step(17);
      check("lat_early_dig", 32'(digits_out), 32'h0);
      check("lat_early_val", 32'(valid_mask), 32'h0);
      step(1);
      check("lat_dig", 32'(digits_out), 32'h0002);
      check("lat_val", 32'(valid_mask), 32'h1);

      // Asynchronous reset mid-SETTLE.
      seg_in = 7'h06;
      step(5);
      #3 rst = 1'b1;
      #1;
      check("arst_digits", 32'(digits_out), 32'h0);
      check("arst_valid",  32'(valid_mask), 32'h0);
      check("arst_err",    32'(pattern_err), 32'h0);
      check("arst_fd",     32'(frame_done), 32'h0);
      step(2);

      // Glitch: a 10-cycle 2 followed by a held 3.
      rst    = 1'b0;
      seg_in = 7'h5B;
      step(10);
      seg_in = 7'h4F;
      step(17);
      check("glitch_early", 32'(digits_out), 32'h0);
      step(1);
      check("glitch_dig", 32'(digits_out), 32'h0003);
      check("glitch_val", 32'(valid_mask), 32'h1);

      // Two full scans, each pulses frame_done once on the digit-3 capture.
      scan(p, s);
      check("scan1_pulses", 32'(p), 32'd1);
      check("scan1_slot",   32'(s), 32'd3);
      check("scan1_digits", 32'(digits_out), 32'h4321);
      check("scan1_valid",  32'(valid_mask), 32'hF);
      scan(p, s);
      check("scan2_pulses", 32'(p), 32'd1);
      check("scan2_slot",   32'(s), 32'd3);

      // Bad pattern on digit 2.
      dig_sel = 4'b0100;
      seg_in  = 7'h01;
      step(20);
      check("bad_err",    32'(pattern_err), 32'h1);
      check("bad_valid",  32'(valid_mask), 32'hB);
      check("bad_digits", 32'(digits_out), 32'h4321);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("clr_err", 32'(pattern_err), 32'h0);
      seg_in = 7'h02;
      step(17);
      check("pre_set_err", 32'(pattern_err), 32'h0);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("set_wins_err", 32'(pattern_err), 32'h1);

      // Non-one-hot selects never capture.
      fd_pulses = 0;
      dig_sel = 4'b0011;
      seg_in  = 7'h06;
      step(40);
      dig_sel = 4'b0000;
      step(40);
      check("nonhot_digits", 32'(digits_out), 32'h4321);
      check("nonhot_valid",  32'(valid_mask), 32'hB);
      check("nonhot_fd",     32'(fd_pulses), 32'd0);

      // Blank on digit 1.
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      dig_sel = 4'b0010;
      seg_in  = 7'h00;
      step(20);
      check("blank_digits", 32'(digits_out), 32'h4301);
      check("blank_valid",  32'(valid_mask), 32'h9);
      check("blank_err",    32'(pattern_err), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
